// File: rtl/mux4_rr_sched.sv
// rtl/mux4_rr_sched.sv - round-robin burst scheduler driving the select pair of a 4:1 mux
// Grants one requester at a time for up to MAX_BURST cycles, then rotates priority past it.
module mux4_rr_sched #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             busy,
  output logic [CNT_W-1:0] owner_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1
  } state_t;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       rot_ptr;
  logic [2:0]       pick;

  // Returns {found, index}; scanning high offsets first lets the lowest offset from p win.
  function automatic logic [2:0] search(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign rot_ptr = sel_q + 2'd1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    pick    = 3'b000;
    case (state_q)
      IDLE: begin
        pick = search(req, ptr_q);
        if (pick[2]) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << pick[1:0];
          sel_d   = pick[1:0];
          cnt_d   = ONE_C;
        end else begin
          gnt_d = 4'b0000;
          cnt_d = '0;
        end
      end
      GRANT: begin
        if (req[sel_q] && (cnt_q < MAX_C)) begin
          cnt_d = cnt_q + ONE_C;
        end else begin
          // Rotating past the releasing owner makes it the last candidate of the rescan.
          ptr_d = rot_ptr;
          pick  = search(req, rot_ptr);
          if (pick[2]) begin
            gnt_d = 4'b0001 << pick[1:0];
            sel_d = pick[1:0];
            cnt_d = ONE_C;
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= |gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign busy      = busy_q;
  assign owner_cnt = cnt_q;

endmodule
